// File: rtl/softmax_sched.sv
// Sequences 16-beat score tiles from the score buffer into the softmax engine and writes probabilities back.
// Latency: first engine start 1 cycle after job accept, 17-cycle tile period, done 1 cycle after the final write.
// Backpressure: i_pb_ready stalls only before a tile is issued; an issued tile always streams to completion.
module softmax_sched #(
   parameter int AW = 12,
   parameter int TW = 8
) (
   input  logic            i_clk,
   input  logic            i_rst_n,
   input  logic            i_start,
   input  logic [AW-1:0]   i_base,
   input  logic [TW-1:0]   i_ntiles,
   input  logic            i_pb_ready,
   output logic            o_busy,
   output logic            o_done,
   output logic            o_sb_ren,
   output logic [AW-1:0]   o_sb_raddr,
   input  logic [639:0]    i_sb_rdata,
   output logic            o_sm_start,
   output logic [639:0]    o_sm_data,
   input  logic            i_sm_y_valid,
   input  logic [127:0]    i_sm_y,
   input  logic            i_sm_denom_valid,
   input  logic [255:0]    i_sm_denom,
   output logic            o_pb_wen,
   output logic [AW-1:0]   o_pb_waddr,
   output logic [127:0]    o_pb_wdata,
   output logic            o_denom_valid,
   output logic [255:0]    o_denom,
   output logic [TW-1:0]   o_denom_tile
);

   // write counter = {tile, beat}
   localparam int CW = TW + 4;

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_STREAM,
      S_LAST,
      S_GAP,
      S_DRAIN
   } state_t;

   state_t          state;
   state_t          state_nxt;
   logic [AW-1:0]   base_q;
   logic [TW-1:0]   ntiles_q;
   logic [TW-1:0]   tile_cnt;
   logic [TW-1:0]   tile_nxt;
   logic [3:0]      beat_cnt;
   logic [CW-1:0]   wr_cnt;
   logic            zero_done_q;
   logic            drain_done;
   logic            accept;
   logic [AW-1:0]   rd_addr;

   assign accept   = (state == S_IDLE) && i_start;
   assign tile_nxt = tile_cnt + TW'(1);

   // Read address of the beat being requested this cycle; held at 0 when no read is issued.
   assign rd_addr    = base_q + AW'({tile_cnt, 4'b0000}) + AW'(beat_cnt);
   assign o_sb_raddr = o_sb_ren ? rd_addr : '0;

   assign o_sm_data  = i_sb_rdata;
   assign o_busy     = (state != S_IDLE);
   assign o_done     = zero_done_q | drain_done;
   assign o_pb_waddr = AW'(wr_cnt);

   // Next-state and engine/read strobes. S_LAST hands straight to the next S_START so the
   // engine's idle cycle is the one carrying the next start pulse; S_GAP only follows the final tile.
   always_comb begin
      state_nxt  = state;
      o_sm_start = 1'b0;
      o_sb_ren   = 1'b0;
      drain_done = 1'b0;
      case (state)
         S_IDLE: begin
            if (i_start && (i_ntiles != '0)) state_nxt = S_START;
         end
         S_START: begin
            if (i_pb_ready) begin
               o_sm_start = 1'b1;
               o_sb_ren   = 1'b1;
               state_nxt  = S_STREAM;
            end
         end
         S_STREAM: begin
            o_sb_ren = 1'b1;
            if (beat_cnt == 4'd15) state_nxt = S_LAST;
         end
         S_LAST: begin
            state_nxt = (tile_nxt < ntiles_q) ? S_START : S_GAP;
         end
         S_GAP: begin
            state_nxt = S_DRAIN;
         end
         S_DRAIN: begin
            if (wr_cnt == {ntiles_q, 4'b0000}) begin
               drain_done = 1'b1;
               state_nxt  = S_IDLE;
            end
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   // Sequencer state, job parameters and tile/beat counters.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state       <= S_IDLE;
         base_q      <= '0;
         ntiles_q    <= '0;
         tile_cnt    <= '0;
         beat_cnt    <= '0;
         zero_done_q <= 1'b0;
      end else begin
         state       <= state_nxt;
         zero_done_q <= accept && (i_ntiles == '0);
         if (accept) begin
            base_q   <= i_base;
            ntiles_q <= i_ntiles;
            tile_cnt <= '0;
         end
         if ((state == S_START) && i_pb_ready) beat_cnt <= 4'd1;
         else if (state == S_STREAM)           beat_cnt <= beat_cnt + 4'd1;
         if (state == S_LAST) tile_cnt <= tile_nxt;
      end
   end

   // Probability write path: one registered write per engine beat, address from the free-running write counter.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         o_pb_wen   <= 1'b0;
         o_pb_wdata <= '0;
         wr_cnt     <= '0;
      end else begin
         o_pb_wen <= i_sm_y_valid;
         if (i_sm_y_valid) o_pb_wdata <= i_sm_y;
         if (accept)        wr_cnt <= '0;
         else if (o_pb_wen) wr_cnt <= wr_cnt + CW'(1);
      end
   end

   // Denominator forwarding, tagged with the tile currently being written.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         o_denom_valid <= 1'b0;
         o_denom       <= '0;
         o_denom_tile  <= '0;
      end else begin
         o_denom_valid <= i_sm_denom_valid;
         if (i_sm_denom_valid) begin
            o_denom      <= i_sm_denom;
            o_denom_tile <= wr_cnt[CW-1:4];
         end
      end
   end

endmodule
